// File: rtl/aqed_pkg.sv
// Shared types and constants for the multi-pair A-QED checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aqed_pkg;

    // Checker run state: issue originals, wait for the duplicate, drain, finished.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DUP = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_NUM_PAIRS    = 4;
    localparam int DEF_STOP_ON_FAIL = 0;

    // Width of a slot index (up to 16 pairs) and of the issued-pair count (0..16).
    localparam int SLOT_IDX_W = 4;
    localparam int PAIR_CNT_W = SLOT_IDX_W + 1;

endpackage

// File: rtl/aqed_pair_slot.sv
// One original/duplicate pair: stores issue indices, original data, captured outputs and verdict.
// Latency: capture on the matching output edge; verdict registered one cycle after both captures.
// Backpressure: none; state only advances while clk_en is high.
module aqed_pair_slot
    import aqed_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              i_orig_we,
    input  logic              i_dup_we,
    input  logic [CNT_W-1:0]  i_in_cnt,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_cap_en,
    input  logic [CNT_W-1:0]  i_out_cnt,
    input  logic [DATA_W-1:0] i_out_dat,
    output logic [DATA_W-1:0] o_orig_dat,
    output logic              o_resolved,
    output logic              o_res_now,
    output logic              o_miss_now,
    output logic              o_mismatch
);

    logic [CNT_W-1:0]  r_orig_idx;
    logic [CNT_W-1:0]  r_dup_idx;
    logic [DATA_W-1:0] r_orig_dat;
    logic [DATA_W-1:0] r_orig_out;
    logic [DATA_W-1:0] r_dup_out;
    logic              r_orig_vld;
    logic              r_dup_vld;
    logic              r_orig_cap;
    logic              r_dup_cap;
    logic              r_resolved;
    logic              r_mismatch;

    logic              w_cap_orig;
    logic              w_cap_dup;
    logic              w_res_now;

    // The captured flags block re-capture once a narrow counter wraps back onto a stored index.
    assign w_cap_orig = i_cap_en & r_orig_vld & ~r_orig_cap & (i_out_cnt == r_orig_idx);
    assign w_cap_dup  = i_cap_en & r_dup_vld  & ~r_dup_cap  & (i_out_cnt == r_dup_idx);
    assign w_res_now  = r_orig_cap & r_dup_cap & ~r_resolved;

    assign o_orig_dat = r_orig_dat;
    assign o_resolved = r_resolved;
    assign o_res_now  = w_res_now;
    assign o_miss_now = w_res_now & (r_orig_out != r_dup_out);
    assign o_mismatch = r_mismatch;

    // Slot state: record issue indices, capture the two outputs, then latch the verdict once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_orig_idx <= '0;
            r_dup_idx  <= '0;
            r_orig_dat <= '0;
            r_orig_out <= '0;
            r_dup_out  <= '0;
            r_orig_vld <= 1'b0;
            r_dup_vld  <= 1'b0;
            r_orig_cap <= 1'b0;
            r_dup_cap  <= 1'b0;
            r_resolved <= 1'b0;
            r_mismatch <= 1'b0;
        end else if (clk_en) begin
            if (i_orig_we) begin
                r_orig_idx <= i_in_cnt;
                r_orig_dat <= i_data;
                r_orig_vld <= 1'b1;
            end
            if (i_dup_we) begin
                r_dup_idx <= i_in_cnt;
                r_dup_vld <= 1'b1;
            end
            if (w_cap_orig) begin
                r_orig_out <= i_out_dat;
                r_orig_cap <= 1'b1;
            end
            if (w_cap_dup) begin
                r_dup_out <= i_out_dat;
                r_dup_cap <= 1'b1;
            end
            if (w_res_now) begin
                r_resolved <= 1'b1;
                r_mismatch <= (r_orig_out != r_dup_out);
            end
        end
    end

endmodule

// File: rtl/aqed_multi_pair.sv
// A-QED checker: issues NUM_PAIRS original/duplicate pairs into a DUT and compares their outputs.
// Latency: data_out is combinational; a pair's verdict lands one cycle after its second capture.
// Backpressure: flush stalls issue and input counting; clk_en freezes all state.
module aqed_multi_pair
    import aqed_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int NUM_PAIRS    = DEF_NUM_PAIRS,
    parameter int STOP_ON_FAIL = DEF_STOP_ON_FAIL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  exec_dup,
    input  logic                  wen_in,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    input  logic                  valid_out,
    input  logic [DATA_W-1:0]     data_out_in,
    output logic                  qed_done,
    output logic                  qed_check,
    output logic                  qed_fail,
    output logic [SLOT_IDX_W-1:0] fail_idx
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_in_count;
    logic [CNT_W-1:0]      r_out_count;
    logic [PAIR_CNT_W-1:0] r_pairs_issued;
    logic [SLOT_IDX_W-1:0] r_fail_idx;

    logic                  w_acc_in;
    logic                  w_acc_out;
    logic                  w_issue_orig;
    logic                  w_issue_dup;
    logic                  w_cap_en;
    logic                  w_last_dup;
    logic                  w_all_res;
    logic                  w_any_miss;
    logic                  w_fail;
    logic [SLOT_IDX_W-1:0] w_miss_idx;
    logic [DATA_W-1:0]     w_dup_dat;

    logic [NUM_PAIRS-1:0]  w_orig_we;
    logic [NUM_PAIRS-1:0]  w_dup_we;
    logic [NUM_PAIRS-1:0]  w_resolved;
    logic [NUM_PAIRS-1:0]  w_res_now;
    logic [NUM_PAIRS-1:0]  w_miss_now;
    logic [NUM_PAIRS-1:0]  w_mismatch;
    logic [DATA_W-1:0]     w_slot_dat [NUM_PAIRS];

    assign w_acc_in     = clk_en & wen_in & ~flush & reset;
    assign w_acc_out    = clk_en & wen_in & valid_out & reset;
    assign w_issue_orig = w_acc_in & exec_dup & (r_state == ST_IDLE);
    assign w_issue_dup  = w_acc_in & exec_dup & (r_state == ST_WAIT_DUP);
    assign w_cap_en     = w_acc_out & (r_state != ST_DONE);
    assign w_last_dup   = ((r_pairs_issued + PAIR_CNT_W'(1)) == PAIR_CNT_W'(NUM_PAIRS));

    genvar j;
    generate
        for (j = 0; j < NUM_PAIRS; j++) begin : g_slot
            assign w_orig_we[j] = w_issue_orig & (r_pairs_issued == PAIR_CNT_W'(j));
            assign w_dup_we[j]  = w_issue_dup  & (r_pairs_issued == PAIR_CNT_W'(j));

            aqed_pair_slot #(
                .DATA_W (DATA_W),
                .CNT_W  (CNT_W)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .clk_en     (clk_en),
                .i_orig_we  (w_orig_we[j]),
                .i_dup_we   (w_dup_we[j]),
                .i_in_cnt   (r_in_count),
                .i_data     (data_in),
                .i_cap_en   (w_cap_en),
                .i_out_cnt  (r_out_count),
                .i_out_dat  (data_out_in),
                .o_orig_dat (w_slot_dat[j]),
                .o_resolved (w_resolved[j]),
                .o_res_now  (w_res_now[j]),
                .o_miss_now (w_miss_now[j]),
                .o_mismatch (w_mismatch[j])
            );
        end
    endgenerate

    // Slot summary: all-resolved (counting this cycle's verdicts), failure now, lowest failing index.
    always_comb begin
        w_all_res  = &(w_resolved | w_res_now);
        w_any_miss = |w_miss_now;
        w_miss_idx = '0;
        for (int k = NUM_PAIRS - 1; k >= 0; k--) begin
            if (w_miss_now[k]) begin
                w_miss_idx = SLOT_IDX_W'(k);
            end
        end
    end

    // Select the stored original of the pair currently awaiting its duplicate.
    always_comb begin
        w_dup_dat = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (r_pairs_issued == PAIR_CNT_W'(k)) begin
                w_dup_dat = w_slot_dat[k];
            end
        end
    end

    // The duplicate carries the original's data; every other cycle passes the driver straight through.
    assign data_out = w_issue_dup ? w_dup_dat : data_in;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: issue sequencing, with completion or early stop taking priority.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue_orig) begin
                    w_state_nxt = ST_WAIT_DUP;
                end
            end
            ST_WAIT_DUP: begin
                if (w_issue_dup) begin
                    w_state_nxt = w_last_dup ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DRAIN;
            end
            default: begin
                w_state_nxt = ST_DONE;
            end
        endcase
        if ((r_state != ST_DONE) &&
            (w_all_res || ((STOP_ON_FAIL != 0) && w_any_miss))) begin
            w_state_nxt = ST_DONE;
        end
    end

    // Input/output sequence counters and issued-pair count; counters wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_count     <= '0;
            r_out_count    <= '0;
            r_pairs_issued <= '0;
        end else begin
            if (w_acc_in) begin
                r_in_count <= r_in_count + CNT_W'(1);
            end
            if (w_acc_out) begin
                r_out_count <= r_out_count + CNT_W'(1);
            end
            if (w_issue_dup) begin
                r_pairs_issued <= r_pairs_issued + PAIR_CNT_W'(1);
            end
        end
    end

    // First-failure index: latched only while no slot has failed yet.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fail_idx <= '0;
        end else if (clk_en && w_any_miss && !w_fail) begin
            r_fail_idx <= w_miss_idx;
        end
    end

    // Slot mismatch flags are sticky until reset, so their OR is the sticky failure flag.
    assign w_fail    = |w_mismatch;
    assign qed_fail  = w_fail;
    assign qed_done  = (r_state == ST_DONE);
    assign qed_check = qed_done & ~w_fail;
    assign fail_idx  = r_fail_idx;

endmodule

// File: tb/tb_aqed_multi_pair.sv
module tb_aqed_multi_pair;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic        exec_dup;
    logic        wen_in;
    logic [15:0] data_in;

    // Instance 0: defaults; 1: STOP_ON_FAIL=1; 2: CNT_W=4.
    wire  [15:0] dout0, dout1, dout2;
    wire         done0, done1, done2;
    wire         chk0, chk1, chk2;
    wire         fail0, fail1, fail2;
    wire  [3:0]  fidx0, fidx1, fidx2;

    // Identity DUT model, 2-cycle latency, one per instance.
    logic [15:0] dout_a [3];
    logic [15:0] s1_d   [3];
    logic [15:0] s2_d   [3];
    logic        s1_v   [3];
    logic        s2_v   [3];
    int          cp     [3];
    int          drv_dup_pair;

    int          n_tests;
    int          n_fail;
    int          fill_ctr;
    logic [31:0] exp_in;

    always #5 clk = ~clk;

    assign dout_a[0] = dout0;
    assign dout_a[1] = dout1;
    assign dout_a[2] = dout2;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                s1_v[i] <= 1'b0;
                s2_v[i] <= 1'b0;
                s1_d[i] <= 16'h0;
                s2_d[i] <= 16'h0;
            end else if (clk_en) begin
                s1_v[i] <= wen_in && !flush;
                s1_d[i] <= (drv_dup_pair >= 0 && drv_dup_pair == cp[i]) ? (dout_a[i] & 16'hFFF0) : dout_a[i];
                s2_v[i] <= s1_v[i];
                s2_d[i] <= s1_d[i];
            end
        end
    end

    aqed_multi_pair #(.DATA_W(16), .CNT_W(32), .NUM_PAIRS(4), .STOP_ON_FAIL(0)) dut0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
        .wen_in(wen_in), .data_in(data_in), .data_out(dout0), .valid_out(s2_v[0]),
        .data_out_in(s2_d[0]), .qed_done(done0), .qed_check(chk0), .qed_fail(fail0),
        .fail_idx(fidx0));

    aqed_multi_pair #(.DATA_W(16), .CNT_W(32), .NUM_PAIRS(4), .STOP_ON_FAIL(1)) dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
        .wen_in(wen_in), .data_in(data_in), .data_out(dout1), .valid_out(s2_v[1]),
        .data_out_in(s2_d[1]), .qed_done(done1), .qed_check(chk1), .qed_fail(fail1),
        .fail_idx(fidx1));

    aqed_multi_pair #(.DATA_W(16), .CNT_W(4), .NUM_PAIRS(4), .STOP_ON_FAIL(0)) dut2 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
        .wen_in(wen_in), .data_in(data_in), .data_out(dout2), .valid_out(s2_v[2]),
        .data_out_in(s2_d[2]), .qed_done(done2), .qed_check(chk2), .qed_fail(fail2),
        .fail_idx(fidx2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; tracks the expected input count.
    task automatic step(input logic ed, input logic [15:0] d, input logic fl, input int dp);
        exec_dup     = ed;
        data_in      = d;
        flush        = fl;
        drv_dup_pair = dp;
        @(posedge clk);
        #1;
        if (reset && clk_en && wen_in && !fl) exp_in = exp_in + 32'd1;
        drv_dup_pair = -1;
        fill_ctr++;
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'(32'hA000 + fill_ctr), 1'b0, -1);
    endtask

    // Original, two fillers, duplicate, three fillers: the pair has resolved when this returns.
    task automatic issue_pair(input int p);
        step(1'b1, 16'(32'h1111 * (p + 1)), 1'b0, -1);
        filler(2);
        step(1'b1, 16'hDEAD, 1'b0, p);
        filler(3);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        exec_dup = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        exp_in = 32'd0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; fill_ctr = 0; exp_in = 32'd0; drv_dup_pair = -1;
        for (int i = 0; i < 3; i++) cp[i] = -1;
        reset = 1'b0; clk_en = 1'b1; wen_in = 1'b1; flush = 1'b0; exec_dup = 1'b1; data_in = 16'h5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        check("rst_done", done0, 0);
        check("rst_check", chk0, 0);
        check("rst_fail", fail0, 0);
        check("rst_fidx", fidx0, 0);
        check("rst_in_count", dut0.r_in_count, 0);
        check("rst_dout_pass", dout0, 16'h5A5A);
        reset = 1'b1; exec_dup = 1'b0;

        // Clean run of four pairs
        issue_pair(0);
        check("s1_pairs1", dut0.r_pairs_issued, 1);
        issue_pair(1);
        issue_pair(2);
        check("s1_not_done", done0, 0);
        issue_pair(3);
        check("s1_done", done0, 1);
        check("s1_check", chk0, 1);
        check("s1_fail", fail0, 0);
        check("s1_in_count", dut0.r_in_count, exp_in);
        check("s1_sof_check", chk1, 1);

        // Duplicate of pair 2 corrupted, run continues to the end
        do_reset();
        cp[0] = 2;
        issue_pair(0);
        issue_pair(1);
        issue_pair(2);
        check("s2_fail_mid", fail0, 1);
        check("s2_not_done_mid", done0, 0);
        issue_pair(3);
        check("s2_done", done0, 1);
        check("s2_fail", fail0, 1);
        check("s2_fidx", fidx0, 2);
        check("s2_check", chk0, 0);
        cp[0] = -1;

        // STOP_ON_FAIL with pair 0 corrupted
        do_reset();
        cp[1] = 0;
        issue_pair(0);
        check("s3_done", done1, 1);
        check("s3_check", chk1, 0);
        check("s3_fail", fail1, 1);
        check("s3_fidx", fidx1, 0);
        check("s3_nosof_not_done", done0, 0);
        filler(2);
        check("s3_done_held", done1, 1);
        cp[1] = -1;

        // Flush and clock-enable stalls while waiting for the duplicate
        do_reset();
        step(1'b1, 16'h1111, 1'b0, -1);
        clk_en = 1'b0;
        step(1'b0, 16'h0BAD, 1'b0, -1);
        check("s4_clken_frozen", dut0.r_in_count, 1);
        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exec_dup = 1'b1; data_in = 16'hBEEF; flush = 1'b1;
            #1;
            check("s4_flush_dout", dout0, 16'hBEEF);
            step(1'b1, 16'hBEEF, 1'b1, -1);
            check("s4_flush_frozen", dut0.r_in_count, 1);
            check("s4_flush_state", 32'(dut0.r_state), 1);
        end
        exec_dup = 1'b1; data_in = 16'hDEAD; flush = 1'b0;
        #1;
        check("s4_dup_dout", dout0, 16'h1111);
        step(1'b1, 16'hDEAD, 1'b0, 0);
        filler(3);
        check("s4_in_count", dut0.r_in_count, exp_in);
        issue_pair(1);
        issue_pair(2);
        issue_pair(3);
        check("s4_done", done0, 1);
        check("s4_check", chk0, 1);

        // Mid-run reset, then a full replay
        do_reset();
        issue_pair(0);
        issue_pair(1);
        check("s5_pairs2", dut0.r_pairs_issued, 2);
        do_reset();
        check("s5_pairs0", dut0.r_pairs_issued, 0);
        check("s5_rst_done", done0, 0);
        issue_pair(0);
        check("s5_pairs_restart", dut0.r_pairs_issued, 1);
        issue_pair(1);
        issue_pair(2);
        issue_pair(3);
        check("s5_done", done0, 1);
        check("s5_check", chk0, 1);
        check("s5_fail", fail0, 0);

        // Narrow counters wrap before and during the run
        do_reset();
        filler(20);
        check("s6_wrap_count", dut2.r_in_count, 4);
        issue_pair(0);
        issue_pair(1);
        issue_pair(2);
        issue_pair(3);
        check("s6_done", done2, 1);
        check("s6_check", chk2, 1);
        check("s6_fail", fail2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
